// File: rtl/preg_free_list_ctrl_if.sv
// Rename-stage bundle between the free-list controller, its allocation
// requesters, the commit-side release lanes and the free-list FIFO.
interface preg_free_list_ctrl_if #(
  parameter int NUM_REQ    = 2,
  parameter int NUM_REL    = 2,
  parameter int PREG_WIDTH = 6
);
  logic [NUM_REQ-1:0]                 req;
  logic [NUM_REQ-1:0]                 gnt;
  logic [PREG_WIDTH-1:0]              gnt_preg;
  logic [NUM_REL-1:0]                 rel_valid;
  logic [NUM_REL-1:0][PREG_WIDTH-1:0] rel_preg;
  logic                               flush;
  logic [NUM_REL-1:0]                 fl_wr_en;
  logic [NUM_REL-1:0][PREG_WIDTH-1:0] fl_wr_data;
  logic                               fl_rd_en;
  logic [PREG_WIDTH-1:0]              fl_rd_data;
  logic                               fl_empty;
  logic                               init_done;
  logic [PREG_WIDTH:0]                free_count;

  // Controller side.
  modport master (
    input  req, rel_valid, rel_preg, flush, fl_rd_data, fl_empty,
    output gnt, gnt_preg, fl_wr_en, fl_wr_data, fl_rd_en, init_done, free_count
  );

  // Requesters, commit lanes and FIFO side.
  modport slave (
    output req, rel_valid, rel_preg, flush, fl_rd_data, fl_empty,
    input  gnt, gnt_preg, fl_wr_en, fl_wr_data, fl_rd_en, init_done, free_count
  );
endinterface

// File: rtl/preg_free_list_ctrl.sv
// Physical-register free-list controller: seeds the FIFO after reset,
// round-robin shares its pop port, merges commit releases into its write
// lanes and blocks allocation for a short window after a flush.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_INIT | pushing ARCH_REGS..PHYS_REGS-1 into the FIFO, one per cycle
//   ST_RUN  | arbitrating pops, passing releases through
//   ST_HOLD | post-flush window: no grants, releases still accepted
module preg_free_list_ctrl #(
  parameter int NUM_REQ           = 2,
  parameter int NUM_REL           = 2,
  parameter int PREG_WIDTH        = 6,
  parameter int ARCH_REGS         = 32,
  parameter int PHYS_REGS         = 64,
  parameter int FLUSH_HOLD_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  preg_free_list_ctrl_if.master bus
);

  localparam int RR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HOLD_W = (FLUSH_HOLD_CYCLES > 1) ? $clog2(FLUSH_HOLD_CYCLES) : 1;
  localparam int CNT_W  = PREG_WIDTH + 1;
  localparam int SUM_W  = CNT_W + 1;

  localparam logic [PREG_WIDTH-1:0] SEED_FIRST = PREG_WIDTH'(ARCH_REGS);
  localparam logic [PREG_WIDTH-1:0] SEED_LAST  = PREG_WIDTH'(PHYS_REGS - 1);
  localparam logic [HOLD_W-1:0]     HOLD_LOAD  = HOLD_W'(FLUSH_HOLD_CYCLES - 1);
  localparam logic [SUM_W-1:0]      FREE_MAX   = SUM_W'(PHYS_REGS - ARCH_REGS);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t                             state_q;
  state_t                             state_d;
  logic [PREG_WIDTH-1:0]              seed_q;
  logic [RR_W-1:0]                    rr_q;
  logic [RR_W-1:0]                    rr_nxt;
  logic [HOLD_W-1:0]                  hold_q;
  logic [CNT_W-1:0]                   free_count_q;
  logic [CNT_W-1:0]                   free_count_d;
  logic                               init_done_q;

  logic [NUM_REQ-1:0]                 arb_gnt;
  logic [RR_W-1:0]                    arb_idx;
  logic [RR_W-1:0]                    scan_idx;
  logic                               arb_hit;

  logic [NUM_REQ-1:0]                 gnt_c;
  logic [NUM_REL-1:0]                 wr_en_c;
  logic [NUM_REL-1:0][PREG_WIDTH-1:0] wr_data_c;
  logic                               grant_any;

  logic [SUM_W-1:0]                   free_sum;
  logic [SUM_W-1:0]                   free_wide;
  logic                               free_underflow;
  logic                               free_overflow;

  function automatic logic [SUM_W-1:0] count_ones(input logic [NUM_REL-1:0] v);
    logic [SUM_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_REL; i++) begin
      n = n + SUM_W'(v[i]);
    end
    return n;
  endfunction

  // State register; reset always lands in seeding.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: seeding ends after the last physical register is pushed,
  // a flush (re)starts the hold window, an expired window resumes RUN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT: if (seed_q == SEED_LAST) state_d = ST_RUN;
      ST_RUN:  if (bus.flush) state_d = ST_HOLD;
      ST_HOLD: if (!bus.flush && hold_q == '0) state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  // Round-robin scan starting at rr_q; the first active requester wins.
  always_comb begin
    int idx;
    arb_gnt  = '0;
    arb_idx  = '0;
    scan_idx = '0;
    arb_hit  = 1'b0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      scan_idx = RR_W'(idx);
      if (!arb_hit && bus.req[scan_idx]) begin
        arb_hit = 1'b1;
        arb_idx = scan_idx;
      end
    end
    if (arb_hit) arb_gnt[arb_idx] = 1'b1;
  end

  assign rr_nxt = (int'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + 1'b1;

  // Outputs: seed pushes on lane 0 in INIT, release pass-through otherwise;
  // grants only in RUN, never in a flush cycle and never from an empty FIFO.
  always_comb begin
    gnt_c     = '0;
    wr_en_c   = '0;
    wr_data_c = '0;
    if (!reset) begin
      unique case (state_q)
        ST_INIT: begin
          wr_en_c[0]   = 1'b1;
          wr_data_c[0] = seed_q;
        end
        ST_RUN: begin
          wr_en_c   = bus.rel_valid;
          wr_data_c = bus.rel_preg;
          if (!bus.flush && !bus.fl_empty) gnt_c = arb_gnt;
        end
        ST_HOLD: begin
          wr_en_c   = bus.rel_valid;
          wr_data_c = bus.rel_preg;
        end
        default: ;
      endcase
    end
  end

  assign grant_any = |gnt_c;

  // Free-count update, computed one bit wider so that wrap in either
  // direction is visible to the accounting checks.
  always_comb begin
    free_sum = {1'b0, free_count_q};
    if (state_q == ST_INIT) begin
      free_sum = free_sum + SUM_W'(1);
    end else begin
      free_sum = free_sum + count_ones(bus.rel_valid);
    end
    free_underflow = free_sum < SUM_W'(grant_any);
    free_wide      = free_sum - SUM_W'(grant_any);
    free_overflow  = free_wide > FREE_MAX;
    free_count_d   = free_wide[CNT_W-1:0];
  end

  // Seed counter, round-robin pointer, hold timer, free count, init flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      seed_q       <= SEED_FIRST;
      rr_q         <= '0;
      hold_q       <= '0;
      free_count_q <= '0;
      init_done_q  <= 1'b0;
    end else begin
      if (state_q == ST_INIT) seed_q <= seed_q + 1'b1;
      if (grant_any) rr_q <= rr_nxt;
      if (state_q != ST_INIT && bus.flush) begin
        hold_q <= HOLD_LOAD;
      end else if (state_q == ST_HOLD && hold_q != '0) begin
        hold_q <= hold_q - 1'b1;
      end
      free_count_q <= free_count_d;
      init_done_q  <= (state_d != ST_INIT);
    end
  end

  // Simulation-only guards on release timing and free-list accounting.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(state_q == ST_INIT && |bus.rel_valid))
        else $error("preg_free_list_ctrl: release during seeding");
      assert (!free_underflow)
        else $error("preg_free_list_ctrl: free_count underflow");
      assert (!free_overflow)
        else $error("preg_free_list_ctrl: free_count overflow");
    end
  end

  assign bus.gnt        = gnt_c;
  assign bus.fl_rd_en   = grant_any;
  assign bus.gnt_preg   = bus.fl_rd_data;
  assign bus.fl_wr_en   = wr_en_c;
  assign bus.fl_wr_data = wr_data_c;
  assign bus.init_done  = init_done_q;
  assign bus.free_count = free_count_q;

endmodule

// File: tb/tb_preg_free_list_ctrl.sv
// Bench for preg_free_list_ctrl: a queue-based FIFO fed by the DUT's write
// lanes, plus an independent free-list model (ordered list of free regs,
// round-robin pointer, blocked-cycle count) that predicts every output.
module tb_preg_free_list_ctrl;
  localparam int NR   = 2;
  localparam int NL   = 2;
  localparam int PW   = 6;
  localparam int CW   = PW + 1;
  localparam int ARCH = 32;
  localparam int PHYS = 64;
  localparam int FH   = 2;

  logic clk;
  logic reset;

  preg_free_list_ctrl_if #(.NUM_REQ(NR), .NUM_REL(NL), .PREG_WIDTH(PW)) bus ();

  preg_free_list_ctrl #(
    .NUM_REQ(NR), .NUM_REL(NL), .PREG_WIDTH(PW),
    .ARCH_REGS(ARCH), .PHYS_REGS(PHYS), .FLUSH_HOLD_CYCLES(FH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [PW-1:0] fifo[$];
  int            m_free[$];
  int            held[$];
  bit            m_seeding   = 1'b1;
  int            m_next_seed = ARCH;
  int            m_rr        = 0;
  int            m_block     = 0;
  bit            m_init_done = 1'b0;
  int            m_gidx      = 0;

  logic [NR-1:0]         obs_gnt, exp_gnt;
  logic                  obs_rd_en, exp_rd_en;
  logic [PW-1:0]         obs_preg, exp_preg;
  logic [NL-1:0]         obs_wr_en, exp_wr_en;
  logic [NL-1:0][PW-1:0] obs_wr_data, exp_wr_data;
  logic [CW-1:0]         obs_free_count, exp_free_count;
  logic                  obs_init_done, exp_init_done;

  task automatic run_cycle();
    bit found;
    int i;
    found          = 1'b0;
    exp_gnt        = '0;
    exp_preg       = '0;
    exp_wr_en      = '0;
    exp_wr_data    = '0;
    exp_free_count = CW'(m_free.size());
    exp_init_done  = m_init_done;
    if (!reset) begin
      if (m_seeding) begin
        exp_wr_en      = NL'(1);
        exp_wr_data[0] = PW'(m_next_seed);
      end else begin
        exp_wr_en   = bus.rel_valid;
        exp_wr_data = bus.rel_preg;
        if (!bus.flush && m_block == 0 && m_free.size() > 0) begin
          for (int k = 0; k < NR; k++) begin
            i = (m_rr + k) % NR;
            if (!found && ((bus.req >> i) & NR'(1)) != '0) begin
              found   = 1'b1;
              m_gidx  = i;
              exp_gnt = NR'(1) << i;
            end
          end
          if (found) exp_preg = PW'(m_free[0]);
        end
      end
    end
    exp_rd_en = |exp_gnt;

    @(negedge clk);
    obs_gnt        = bus.gnt;
    obs_rd_en      = bus.fl_rd_en;
    obs_preg       = bus.gnt_preg;
    obs_wr_en      = bus.fl_wr_en;
    obs_wr_data    = bus.fl_wr_data;
    obs_free_count = bus.free_count;
    obs_init_done  = bus.init_done;

    @(posedge clk);
    if (reset) begin
      fifo.delete();
    end else begin
      if (obs_rd_en && fifo.size() > 0) void'(fifo.pop_front());
      for (int l = 0; l < NL; l++) if (obs_wr_en[l]) fifo.push_back(obs_wr_data[l]);
    end

    if (reset) begin
      m_free.delete();
      held.delete();
      m_seeding   = 1'b1;
      m_next_seed = ARCH;
      m_rr        = 0;
      m_block     = 0;
      m_init_done = 1'b0;
    end else if (m_seeding) begin
      m_free.push_back(m_next_seed);
      if (m_next_seed == PHYS - 1) m_seeding = 1'b0;
      m_next_seed++;
      m_init_done = !m_seeding;
    end else begin
      if (found) begin
        held.push_back(m_free.pop_front());
        m_rr = (m_gidx + 1) % NR;
      end
      for (int l = 0; l < NL; l++) if (bus.rel_valid[l]) m_free.push_back(int'(bus.rel_preg[l]));
      if (bus.flush) m_block = FH;
      else if (m_block > 0) m_block--;
    end
    cyc++;
    #1;
    bus.fl_empty   = (fifo.size() == 0);
    bus.fl_rd_data = (fifo.size() > 0) ? fifo[0] : '0;
  endtask

  task automatic clear_inputs();
    bus.req       = '0;
    bus.rel_valid = '0;
    bus.rel_preg  = '0;
    bus.flush     = 1'b0;
  endtask

  task automatic pick_releases(input int pct);
    int j;
    bus.rel_valid = '0;
    bus.rel_preg  = '0;
    for (int l = 0; l < NL; l++) begin
      if (held.size() > 0 && int'($urandom_range(99)) < pct) begin
        j = int'($urandom_range(held.size() - 1));
        bus.rel_valid[l] = 1'b1;
        bus.rel_preg[l]  = PW'(held[j]);
        held.delete(j);
      end
    end
  endtask

  task automatic release_reg(input int lane, input int preg);
    int pos;
    pos = -1;
    for (int j = 0; j < held.size(); j++) if (pos < 0 && held[j] == preg) pos = j;
    if (pos >= 0) held.delete(pos);
    bus.rel_valid[lane] = 1'b1;
    bus.rel_preg[lane]  = PW'(preg);
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.req = '1;
    reset   = 1'b1;
    run_cycle();
    run_cycle();
    n_checks++; if (obs_gnt !== '0 || obs_rd_en !== 1'b0 || obs_wr_en !== '0) $display("FAIL reset_outputs gnt=%b rd_en=%b wr_en=%b required all zero", obs_gnt, obs_rd_en, obs_wr_en); else n_pass++;
    reset = 1'b0;
    for (int c = 0; c < PHYS - ARCH; c++) begin
      bus.req   = NR'($urandom_range(3));
      bus.flush = $urandom_range(1);
      run_cycle();
      if (c == 0) begin
        n_checks++; if (obs_free_count !== 7'd0 || obs_init_done !== 1'b0) $display("FAIL reset_state free_count=%0d init_done=%b required 0/0", obs_free_count, obs_init_done); else n_pass++;
      end
      n_checks++; if (obs_wr_en !== exp_wr_en || obs_wr_data[0] !== exp_wr_data[0]) $display("FAIL seed_push cyc=%0d wr_en=%b data=%0d required %b/%0d", cyc, obs_wr_en, obs_wr_data[0], exp_wr_en, exp_wr_data[0]); else n_pass++;
      n_checks++; if (obs_gnt !== '0) $display("FAIL seed_no_grant cyc=%0d gnt=%b required 0", cyc, obs_gnt); else n_pass++;
      n_checks++; if (obs_free_count !== exp_free_count) $display("FAIL seed_count cyc=%0d free_count=%0d required %0d", cyc, obs_free_count, exp_free_count); else n_pass++;
    end
    clear_inputs();
    run_cycle();
    n_checks++; if (obs_init_done !== 1'b1 || obs_free_count !== 7'd32) $display("FAIL init_done init_done=%b free_count=%0d required 1/32", obs_init_done, obs_free_count); else n_pass++;
  endtask

  task automatic test_alternate();
    logic [NR-1:0] want;
    clear_inputs();
    bus.req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      run_cycle();
      want = (k % 2 == 0) ? 2'b01 : 2'b10;
      n_checks++; if (obs_gnt !== want || obs_preg !== PW'(32 + k)) $display("FAIL alt_grant k=%0d gnt=%b preg=%0d required %b/%0d", k, obs_gnt, obs_preg, want, 32 + k); else n_pass++;
    end
    bus.req = '0;
    run_cycle();
    n_checks++; if (obs_free_count !== 7'd28) $display("FAIL alt_count free_count=%0d required 28", obs_free_count); else n_pass++;
  endtask

  task automatic test_drain();
    int grants;
    int guard;
    grants = 0;
    guard  = 0;
    clear_inputs();
    bus.req = 2'b01;
    while (m_free.size() > 0 && guard < 40) begin
      run_cycle();
      guard++;
      if (obs_gnt == 2'b01) grants++;
      n_checks++; if (obs_gnt !== exp_gnt || (exp_rd_en && obs_preg !== exp_preg)) $display("FAIL drain_grant cyc=%0d gnt=%b preg=%0d required %b/%0d", cyc, obs_gnt, obs_preg, exp_gnt, exp_preg); else n_pass++;
    end
    n_checks++; if (grants != 28) $display("FAIL drain_total grants=%0d required 28", grants); else n_pass++;
    run_cycle();
    n_checks++; if (obs_gnt !== '0 || obs_free_count !== 7'd0) $display("FAIL drain_empty gnt=%b free_count=%0d required 0/0", obs_gnt, obs_free_count); else n_pass++;
    release_reg(0, 40);
    release_reg(1, 41);
    run_cycle();
    n_checks++; if (obs_gnt !== '0 || obs_wr_en !== 2'b11) $display("FAIL no_bypass gnt=%b wr_en=%b required 00/11", obs_gnt, obs_wr_en); else n_pass++;
    bus.rel_valid = '0;
    run_cycle();
    n_checks++; if (obs_gnt !== 2'b01 || obs_preg !== 6'd40 || obs_free_count !== 7'd2) $display("FAIL refill_grant gnt=%b preg=%0d free_count=%0d required 01/40/2", obs_gnt, obs_preg, obs_free_count); else n_pass++;
    bus.req = '0;
    run_cycle();
    n_checks++; if (obs_free_count !== 7'd1) $display("FAIL refill_count free_count=%0d required 1", obs_free_count); else n_pass++;
  endtask

  task automatic test_flush();
    clear_inputs();
    bus.req   = 2'b11;
    bus.flush = 1'b1;
    run_cycle();
    n_checks++; if (obs_gnt !== '0) $display("FAIL flush_cycle gnt=%b required 00", obs_gnt); else n_pass++;
    bus.flush = 1'b0;
    release_reg(0, 50);
    run_cycle();
    n_checks++; if (obs_gnt !== '0 || obs_wr_en !== 2'b01 || obs_wr_data[0] !== 6'd50) $display("FAIL hold_release gnt=%b wr_en=%b data=%0d required 00/01/50", obs_gnt, obs_wr_en, obs_wr_data[0]); else n_pass++;
    bus.rel_valid = '0;
    run_cycle();
    n_checks++; if (obs_gnt !== '0) $display("FAIL hold_block gnt=%b required 00", obs_gnt); else n_pass++;
    run_cycle();
    n_checks++; if (obs_gnt !== 2'b10 || obs_preg !== exp_preg) $display("FAIL post_hold gnt=%b preg=%0d required 10/%0d", obs_gnt, obs_preg, exp_preg); else n_pass++;
    run_cycle();
    n_checks++; if (obs_gnt !== 2'b01 || obs_preg !== 6'd50) $display("FAIL post_hold_rr gnt=%b preg=%0d required 01/50", obs_gnt, obs_preg); else n_pass++;
  endtask

  task automatic test_simultaneous();
    int guard;
    guard = 0;
    clear_inputs();
    while (m_free.size() < 10 && guard < 40) begin
      bus.rel_valid = '0;
      if (10 - m_free.size() >= 2) pick_releases(100);
      else release_reg(0, held[0]);
      run_cycle();
      guard++;
    end
    bus.req = 2'b01;
    pick_releases(100);
    run_cycle();
    n_checks++; if (obs_free_count !== 7'd10 || obs_gnt !== exp_gnt || obs_wr_en !== 2'b11) $display("FAIL simul_cycle free_count=%0d gnt=%b wr_en=%b required 10/%b/11", obs_free_count, obs_gnt, obs_wr_en, exp_gnt); else n_pass++;
    clear_inputs();
    run_cycle();
    n_checks++; if (obs_free_count !== 7'd11) $display("FAIL simul_count free_count=%0d required 11", obs_free_count); else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      bus.req   = NR'($urandom_range(3));
      bus.flush = ($urandom_range(99) < 6);
      pick_releases(40);
      run_cycle();
      n_checks++; if (obs_gnt !== exp_gnt || obs_rd_en !== exp_rd_en) $display("FAIL rnd_grant cyc=%0d gnt=%b rd_en=%b required %b/%b", cyc, obs_gnt, obs_rd_en, exp_gnt, exp_rd_en); else n_pass++;
      if (exp_rd_en) begin
        n_checks++; if (obs_preg !== exp_preg) $display("FAIL rnd_preg cyc=%0d preg=%0d required %0d", cyc, obs_preg, exp_preg); else n_pass++;
      end
      n_checks++; if (obs_wr_en !== exp_wr_en || obs_wr_data !== exp_wr_data) $display("FAIL rnd_write cyc=%0d wr_en=%b data=%h required %b/%h", cyc, obs_wr_en, obs_wr_data, exp_wr_en, exp_wr_data); else n_pass++;
      n_checks++; if (obs_free_count !== exp_free_count || obs_init_done !== exp_init_done) $display("FAIL rnd_count cyc=%0d free_count=%0d init_done=%b required %0d/%b", cyc, obs_free_count, obs_init_done, exp_free_count, exp_init_done); else n_pass++;
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_run();
    int guard;
    guard = 0;
    clear_inputs();
    while (m_free.size() != 5 && guard < 80) begin
      bus.req       = (m_free.size() > 5) ? 2'b01 : 2'b00;
      bus.rel_valid = '0;
      if (m_free.size() < 5) release_reg(0, held[0]);
      run_cycle();
      guard++;
    end
    clear_inputs();
    run_cycle();
    n_checks++; if (obs_free_count !== 7'd5 || obs_init_done !== 1'b1) $display("FAIL pre_reset free_count=%0d init_done=%b required 5/1", obs_free_count, obs_init_done); else n_pass++;
    bus.req = 2'b11;
    reset   = 1'b1;
    run_cycle();
    n_checks++; if (obs_gnt !== '0 || obs_rd_en !== 1'b0 || obs_wr_en !== '0) $display("FAIL mid_reset_outputs gnt=%b rd_en=%b wr_en=%b required all zero", obs_gnt, obs_rd_en, obs_wr_en); else n_pass++;
    reset = 1'b0;
    run_cycle();
    n_checks++; if (obs_free_count !== 7'd0 || obs_init_done !== 1'b0 || obs_wr_en !== 2'b01 || obs_wr_data[0] !== 6'd32) $display("FAIL reseed_start free_count=%0d init_done=%b wr_en=%b data=%0d required 0/0/01/32", obs_free_count, obs_init_done, obs_wr_en, obs_wr_data[0]); else n_pass++;
    for (int c = 1; c < PHYS - ARCH; c++) begin
      run_cycle();
      n_checks++; if (obs_wr_data[0] !== exp_wr_data[0] || obs_gnt !== '0) $display("FAIL reseed_push cyc=%0d data=%0d gnt=%b required %0d/00", cyc, obs_wr_data[0], obs_gnt, exp_wr_data[0]); else n_pass++;
    end
    bus.req = '0;
    run_cycle();
    n_checks++; if (obs_init_done !== 1'b1 || obs_free_count !== 7'd32) $display("FAIL reseed_done init_done=%b free_count=%0d required 1/32", obs_init_done, obs_free_count); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    bus.fl_empty   = 1'b1;
    bus.fl_rd_data = '0;
    clear_inputs();
    #1;
    test_reset();
    test_alternate();
    test_drain();
    test_flush();
    test_simultaneous();
    test_random();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
